// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, sizes and round-robin pick helper for the 4:1 arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANTED} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan ptr+1, ptr+2, ptr+3, ptr; the descending loop lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = ptr + SEL_W'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/mux_4to1_32bit.sv
// mux_4to1_32bit: combinational 4:1 data selector driven by the arbiter's Select.
module mux_4to1_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic [WIDTH-1:0] in3_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = sel_i[1] ? (sel_i[0] ? in3_i : in2_i) : (sel_i[0] ? in1_i : in0_i);
endmodule

// File: rtl/mux_4to1_32bit_arbiter.sv
// mux_4to1_32bit_arbiter: round-robin burst arbiter feeding a registered valid/ready output.
// Optional per-grant beat cap enabled by defining ARB_MAX_HOLD_EN.
module mux_4to1_32bit_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] Last,
  input  logic [WIDTH-1:0]   In0,
  input  logic [WIDTH-1:0]   In1,
  input  logic [WIDTH-1:0]   In2,
  input  logic [WIDTH-1:0]   In3,
  output logic [NUM_REQ-1:0] Ack,
  output logic [NUM_REQ-1:0] Grant,
  output logic [SEL_W-1:0]   Select,
  output logic               Busy,
  output logic [WIDTH-1:0]   Out,
  output logic               Out_valid,
  input  logic               Out_ready
);
  if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
    $error("MAX_BEATS must be within 1..255");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] gidx_q, gidx_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q, out_d, mux_out;
  logic             out_valid_q, out_valid_d;
  logic             granted, can_load, ack_g, cap_hit, release_g;
  pick_t            pick;

  assign granted   = state_q == GRANTED;
  assign can_load  = ~out_valid_q | Out_ready;
  assign ack_g     = granted & Req[gidx_q] & can_load;
  assign release_g = ack_g & (Last[gidx_q] | cap_hit);
  assign pick      = rr_pick(Req, ptr_q);

  assign Grant     = granted ? onehot(gidx_q) : '0;
  assign Ack       = ack_g ? onehot(gidx_q) : '0;
  assign Select    = granted ? gidx_q : '0;
  assign Busy      = granted;
  assign Out       = out_q;
  assign Out_valid = out_valid_q;

  mux_4to1_32bit #(.WIDTH(WIDTH)) u_mux (
    .in0_i (In0),
    .in1_i (In1),
    .in2_i (In2),
    .in3_i (In3),
    .sel_i (Select),
    .out_o (mux_out)
  );

`ifdef ARB_MAX_HOLD_EN
  logic [7:0] cnt_q, cnt_d;
  // cnt_q counts beats already taken, so this Ack is beat cnt_q+1.
  assign cap_hit = ~Last[gidx_q] & (cnt_q == 8'(MAX_BEATS - 1));
  assign cnt_d   = !granted ? 8'd0 : ack_g ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign cap_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    if (!granted) begin
      if (pick.found) begin
        state_d = GRANTED;
        gidx_d  = pick.idx;
      end
    end else if (release_g) begin
      state_d = IDLE;
      ptr_d   = gidx_q;
    end
    out_d       = ack_g ? mux_out : out_q;
    out_valid_d = ack_g | (out_valid_q & ~Out_ready);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      ptr_q       <= SEL_W'(NUM_REQ - 1);
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
